// File: rtl/fp_addsub_pipe.sv
// Three-stage floating-point adder/subtractor, flush-to-zero, round-to-nearest-even.
// A single enable stalls the whole pipeline when the output is held.
module fp_addsub_pipe #(
    parameter int unsigned EXP_W = 5,
    parameter int unsigned MAN_W = 10,
    parameter int unsigned TAG_W = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [EXP_W+MAN_W:0] a,
    input  logic [EXP_W+MAN_W:0] b,
    input  logic                 op,
    input  logic [TAG_W-1:0]     in_tag,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [EXP_W+MAN_W:0] y,
    output logic [TAG_W-1:0]     out_tag,
    output logic                 flag_nv,
    output logic                 flag_of
);
    localparam int unsigned W   = 1 + EXP_W + MAN_W;
    localparam int unsigned M   = MAN_W + 1;
    localparam int unsigned A   = MAN_W + 3;
    localparam int unsigned F   = MAN_W + 4;
    localparam int unsigned SHW = 2 * A;
    localparam int unsigned XW  = EXP_W + 2;
    localparam int unsigned LZW = $clog2(F + 1);
    localparam int unsigned SAW = $clog2(SHW);
    localparam logic [EXP_W-1:0] EMAX = '1;
    localparam logic [W-1:0]     QNAN = {1'b0, EMAX, 1'b1, {(MAN_W-1){1'b0}}};

    function automatic logic [LZW-1:0] lzc(input logic [F-1:0] v);
        logic found;
        found = 1'b0;
        lzc   = '0;
        for (int i = int'(F) - 1; i >= 0; i--) begin
            if (!found) begin
                if (v[i]) found = 1'b1;
                else      lzc   = lzc + LZW'(1);
            end
        end
    endfunction

    logic en;
    assign en       = !out_valid || out_ready;
    assign in_ready = en;

    // Stage 1: unpack, classify, order by magnitude, align the smaller operand
    logic             sa, sb, a_max, b_max, a_nan, b_nan, a_inf, b_inf, a_big;
    logic [EXP_W-1:0] ea, eb, big_e, sm_e, diff;
    logic [M-1:0]     ma, mb, big_m, sm_m;
    logic [SAW-1:0]   shamt;
    logic [SHW-1:0]   sh_in, sh_out;

    logic             v1_q, sign1_q, sub1_q, spec1_q, nv1_q;
    logic             sign1_d, sub1_d, spec1_d, nv1_d;
    logic [TAG_W-1:0] tag1_q;
    logic [EXP_W-1:0] exp1_q, exp1_d;
    logic [F-1:0]     mb1_q, ms1_q, mb1_d, ms1_d;
    logic [W-1:0]     specv1_q, specv1_d;

    always_comb begin
        sa     = a[W-1];
        sb     = b[W-1] ^ op;
        ea     = a[W-2:MAN_W];
        eb     = b[W-2:MAN_W];
        a_max  = &ea;
        b_max  = &eb;
        a_nan  = a_max && (a[MAN_W-1:0] != '0);
        b_nan  = b_max && (b[MAN_W-1:0] != '0);
        a_inf  = a_max && (a[MAN_W-1:0] == '0);
        b_inf  = b_max && (b[MAN_W-1:0] == '0);
        ma     = (ea == '0) ? '0 : {1'b1, a[MAN_W-1:0]};
        mb     = (eb == '0) ? '0 : {1'b1, b[MAN_W-1:0]};
        a_big  = {ea, ma} >= {eb, mb};
        big_e  = a_big ? ea : eb;
        big_m  = a_big ? ma : mb;
        sm_e   = a_big ? eb : ea;
        sm_m   = a_big ? mb : ma;
        diff   = big_e - sm_e;
        shamt  = (32'(diff) > A) ? SAW'(A) : SAW'(diff);
        sh_in  = {sm_m, 2'b00, {A{1'b0}}};
        sh_out = sh_in >> shamt;

        sign1_d  = a_big ? sa : sb;
        sub1_d   = sa ^ sb;
        exp1_d   = big_e;
        mb1_d    = {big_m, 3'b000};
        ms1_d    = {sh_out[SHW-1 -: A], |sh_out[A-1:0]};
        spec1_d  = a_max || b_max;
        nv1_d    = a_nan || b_nan || (a_inf && b_inf && (sa != sb));
        specv1_d = nv1_d ? QNAN :
                   (a_inf ? {sa, EMAX, {MAN_W{1'b0}}} : {sb, EMAX, {MAN_W{1'b0}}});
    end

    // Stage 2: add/subtract magnitudes and normalize
    logic [F:0]       sum;
    logic [LZW-1:0]   lz;
    logic             v2_q, sign2_q, zero2_q, spec2_q, nv2_q;
    logic             sign2_d, zero2_d;
    logic [TAG_W-1:0] tag2_q;
    logic [XW-1:0]    exp2_q, exp2_d;
    logic [A-1:0]     man2_q, man2_d;
    logic [W-1:0]     specv2_q;

    always_comb begin
        sum = sub1_q ? ({1'b0, mb1_q} - {1'b0, ms1_q}) : ({1'b0, mb1_q} + {1'b0, ms1_q});
        lz  = lzc(sum[F-1:0]);
        if (sum[F]) begin
            man2_d = {sum[F-1:2], sum[1] | sum[0]};
            exp2_d = XW'(exp1_q) + XW'(1);
        end else begin
            man2_d = A'(sum[F-1:0] << lz);
            exp2_d = XW'(exp1_q) - XW'(lz);
        end
        zero2_d = (sum == '0);
        // exact cancellation yields +0; like-signed zeros keep their sign
        sign2_d = sign1_q && !(zero2_d && sub1_q);
    end

    // Stage 3: round to nearest even, pack, resolve specials and flags
    logic             inc;
    logic [MAN_W:0]   mr;
    logic [XW-1:0]    exp_r;
    logic             v3_q, nv3_q, of3_q, nv3_d, of3_d;
    logic [TAG_W-1:0] tag3_q;
    logic [W-1:0]     y3_q, y3_d;

    always_comb begin
        inc   = man2_q[2] && (man2_q[1] || man2_q[0] || man2_q[3]);
        mr    = {1'b0, man2_q[A-1:3]} + (MAN_W+1)'(inc);
        exp_r = mr[MAN_W] ? exp2_q + XW'(1) : exp2_q;
        y3_d  = {sign2_q, exp_r[EXP_W-1:0], mr[MAN_W-1:0]};
        nv3_d = 1'b0;
        of3_d = 1'b0;
        if (spec2_q) begin
            y3_d  = specv2_q;
            nv3_d = nv2_q;
        end else if (zero2_q || exp_r[XW-1] || (exp_r == '0)) begin
            y3_d = {sign2_q, {(W-1){1'b0}}};
        end else if (exp_r >= XW'(EMAX)) begin
            y3_d  = {sign2_q, EMAX, {MAN_W{1'b0}}};
            of3_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1_q <= 1'b0; sign1_q <= 1'b0; sub1_q <= 1'b0; spec1_q <= 1'b0; nv1_q <= 1'b0;
            tag1_q <= '0; exp1_q <= '0; mb1_q <= '0; ms1_q <= '0; specv1_q <= '0;
            v2_q <= 1'b0; sign2_q <= 1'b0; zero2_q <= 1'b0; spec2_q <= 1'b0; nv2_q <= 1'b0;
            tag2_q <= '0; exp2_q <= '0; man2_q <= '0; specv2_q <= '0;
            v3_q <= 1'b0; nv3_q <= 1'b0; of3_q <= 1'b0; tag3_q <= '0; y3_q <= '0;
        end else if (en) begin
            v1_q <= in_valid; sign1_q <= sign1_d; sub1_q <= sub1_d; spec1_q <= spec1_d;
            nv1_q <= nv1_d; tag1_q <= in_tag; exp1_q <= exp1_d; mb1_q <= mb1_d;
            ms1_q <= ms1_d; specv1_q <= specv1_d;
            v2_q <= v1_q; sign2_q <= sign2_d; zero2_q <= zero2_d; spec2_q <= spec1_q;
            nv2_q <= nv1_q; tag2_q <= tag1_q; exp2_q <= exp2_d; man2_q <= man2_d;
            specv2_q <= specv1_q;
            v3_q <= v2_q; nv3_q <= nv3_d; of3_q <= of3_d; tag3_q <= tag2_q; y3_q <= y3_d;
        end
    end

    assign out_valid = v3_q;
    assign y         = y3_q;
    assign out_tag   = tag3_q;
    assign flag_nv   = nv3_q;
    assign flag_of   = of3_q;
endmodule

// File: tb/tb_fp_addsub_pipe.sv
// Directed bench for fp_addsub_pipe: binary16 vectors with hand-derived results,
// checked in issue order through a scoreboard queue.
module tb_fp_addsub_pipe;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic        op = 1'b0;
    logic [3:0]  in_tag = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] y;
    logic [3:0]  out_tag;
    logic        flag_nv;
    logic        flag_of;

    fp_addsub_pipe #(.EXP_W(5), .MAN_W(10), .TAG_W(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .op(op), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .y(y), .out_tag(out_tag),
        .flag_nv(flag_nv), .flag_of(flag_of)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] y;
        logic [3:0]  tag;
        logic        nv;
        logic        of;
    } exp_t;

    exp_t sbq[$];
    exp_t pend;
    int   total = 0;
    int   bad   = 0;
    int   w;

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, expv);
        end
    endtask

    // Scoreboard: pop and compare on output transfer, push on input transfer
    always @(negedge clk) begin
        if (rst) begin
            sbq.delete();
        end else begin
            if (out_valid && out_ready) begin
                if (sbq.size() == 0) begin
                    check("spurious_out", 32'(sbq.size()), 32'd1);
                end else begin
                    exp_t e;
                    e = sbq.pop_front();
                    check("y", 32'(y), 32'(e.y));
                    check("out_tag", 32'(out_tag), 32'(e.tag));
                    check("flag_nv", 32'(flag_nv), 32'(e.nv));
                    check("flag_of", 32'(flag_of), 32'(e.of));
                end
            end
            if (in_valid && in_ready) sbq.push_back(pend);
        end
    end

    task automatic issue(input logic [15:0] ia, input logic [15:0] ib, input logic iop,
                         input logic [3:0] itag, input logic [15:0] ey,
                         input logic env, input logic eof, output int waits);
        a = ia; b = ib; op = iop; in_tag = itag;
        pend = '{y: ey, tag: itag, nv: env, of: eof};
        in_valid = 1'b1;
        waits = 0;
        @(negedge clk);
        while (!in_ready && waits < 100) begin
            waits++;
            @(negedge clk);
        end
        if (!in_ready) begin
            check("accept_timeout", 32'(in_ready), 32'd1);
            in_valid = 1'b0;
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sbq.size() != 0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        check("drain_empty", 32'(sbq.size()), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        #12;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_y", 32'(y), 32'd0);
        check("rst_out_tag", 32'(out_tag), 32'd0);
        check("rst_flag_nv", 32'(flag_nv), 32'd0);
        check("rst_flag_of", 32'(flag_of), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1 rst = 1'b0;

        // Basic add right after reset release, with latency check
        issue(16'h3C00, 16'h3C00, 1'b0, 4'd5, 16'h4000, 1'b0, 1'b0, w);
        check("first_edge_accept", 32'(w), 32'd0);
        @(negedge clk); check("lat_c1", 32'(out_valid), 32'd0);
        @(negedge clk); check("lat_c2", 32'(out_valid), 32'd0);
        @(negedge clk); check("lat_c3", 32'(out_valid), 32'd1);
        @(posedge clk); #1;

        // Back-to-back stream at full throughput
        issue(16'h3C00, 16'h3C00, 1'b1, 4'd1, 16'h0000, 1'b0, 1'b0, w);
        issue(16'h3C00, 16'h1000, 1'b0, 4'd2, 16'h3C00, 1'b0, 1'b0, w);
        issue(16'h8001, 16'h8000, 1'b0, 4'd3, 16'h8000, 1'b0, 1'b0, w);
        issue(16'h7BFF, 16'h7BFF, 1'b0, 4'd4, 16'h7C00, 1'b0, 1'b1, w);
        issue(16'h7C00, 16'h7C00, 1'b1, 4'd5, 16'h7E00, 1'b1, 1'b0, w);
        issue(16'h3C01, 16'h1000, 1'b0, 4'd6, 16'h3C02, 1'b0, 1'b0, w);
        issue(16'h3C00, 16'h1001, 1'b0, 4'd7, 16'h3C01, 1'b0, 1'b0, w);
        issue(16'h3C00, 16'h1001, 1'b1, 4'd8, 16'h3BFF, 1'b0, 1'b0, w);
        issue(16'h3C00, 16'h3E00, 1'b1, 4'd9, 16'hB800, 1'b0, 1'b0, w);
        issue(16'h7C00, 16'h3C00, 1'b0, 4'd10, 16'h7C00, 1'b0, 1'b0, w);
        issue(16'h3C00, 16'h7C00, 1'b1, 4'd11, 16'hFC00, 1'b0, 1'b0, w);
        issue(16'h7C01, 16'h0000, 1'b0, 4'd12, 16'h7E00, 1'b1, 1'b0, w);
        issue(16'h0401, 16'h0400, 1'b1, 4'd13, 16'h0000, 1'b0, 1'b0, w);
        issue(16'h4000, 16'h3C00, 1'b1, 4'd14, 16'h3C00, 1'b0, 1'b0, w);
        issue(16'hFC00, 16'h7C00, 1'b0, 4'd15, 16'h7E00, 1'b1, 1'b0, w);
        issue(16'h7800, 16'h7800, 1'b0, 4'd0, 16'h7C00, 1'b0, 1'b1, w);
        issue(16'hC000, 16'h3C00, 1'b0, 4'd1, 16'hBC00, 1'b0, 1'b0, w);
        issue(16'h3C00, 16'h0001, 1'b0, 4'd2, 16'h3C00, 1'b0, 1'b0, w);
        drain();

        // Backpressure: fill the pipe with out_ready low, then release
        out_ready = 1'b0;
        issue(16'h3C00, 16'h3C00, 1'b0, 4'd1, 16'h4000, 1'b0, 1'b0, w);
        issue(16'h4000, 16'h3C00, 1'b1, 4'd2, 16'h3C00, 1'b0, 1'b0, w);
        issue(16'h3C00, 16'h3E00, 1'b1, 4'd3, 16'hB800, 1'b0, 1'b0, w);
        check("bp_in_ready", 32'(in_ready), 32'd0);
        check("bp_out_valid", 32'(out_valid), 32'd1);
        check("bp_y", 32'(y), 32'h4000);
        repeat (2) @(posedge clk);
        #1;
        check("bp_in_ready_held", 32'(in_ready), 32'd0);
        check("bp_y_held", 32'(y), 32'h4000);
        check("bp_tag_held", 32'(out_tag), 32'd1);
        fork
            begin
                issue(16'h7BFF, 16'h7BFF, 1'b0, 4'd4, 16'h7C00, 1'b0, 1'b1, w);
                issue(16'h3C00, 16'h1001, 1'b0, 4'd5, 16'h3C01, 1'b0, 1'b0, w);
                issue(16'h7C00, 16'h7C00, 1'b1, 4'd6, 16'h7E00, 1'b1, 1'b0, w);
            end
            begin
                repeat (3) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        drain();

        // Reset with three operations in flight
        issue(16'h3C00, 16'h3C00, 1'b0, 4'd7, 16'h4000, 1'b0, 1'b0, w);
        issue(16'h3C01, 16'h1000, 1'b0, 4'd8, 16'h3C02, 1'b0, 1'b0, w);
        issue(16'h3C00, 16'h1001, 1'b1, 4'd9, 16'h3BFF, 1'b0, 1'b0, w);
        rst = 1'b1;
        #1;
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_y", 32'(y), 32'd0);
        check("mid_rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("no_stale_out", 32'(out_valid), 32'd0);
        end
        @(posedge clk); #1;
        issue(16'h3C00, 16'h3C00, 1'b0, 4'd10, 16'h4000, 1'b0, 1'b0, w);
        @(negedge clk); check("post_rst_lat_c1", 32'(out_valid), 32'd0);
        @(negedge clk); check("post_rst_lat_c2", 32'(out_valid), 32'd0);
        @(negedge clk); check("post_rst_lat_c3", 32'(out_valid), 32'd1);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
